// File: rtl/upio_in_cond.sv
// Pad input conditioner: synchroniser, per-bit debounce, edge pulses, sticky events, level irq.
// Optional rejected-glitch counter built when UPIO_COND_GLITCH_CNT_EN is defined.
module upio_in_cond #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     pad_i,
  input  logic [CNT_WIDTH-1:0] deb_len_i,
  input  logic [WIDTH-1:0]     rise_en_i,
  input  logic [WIDTH-1:0]     fall_en_i,
  input  logic [WIDTH-1:0]     irq_mask_i,
  input  logic [WIDTH-1:0]     evt_clr_i,
  output logic [WIDTH-1:0]     upio_in_o,
  output logic [WIDTH-1:0]     rise_o,
  output logic [WIDTH-1:0]     fall_o,
  output logic [WIDTH-1:0]     evt_pend_o,
  output logic                 irq_o,
  output logic [15:0]          glitch_cnt_o
);

  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     w_s;
  logic [WIDTH-1:0]     r_f;
  logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]     r_rise;
  logic [WIDTH-1:0]     r_fall;
  logic [WIDTH-1:0]     r_pend;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Counter only runs while s differs from f; the >= test makes a lowered threshold act immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_f    <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_s[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= deb_len_i) begin
          r_f[i]    <= w_s[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= w_s[i];
          r_fall[i] <= ~w_s[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Set has priority over clear so an event landing on the clear cycle is not lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~evt_clr_i) | (r_rise & rise_en_i) | (r_fall & fall_en_i);
    end
  end

`ifdef UPIO_COND_GLITCH_CNT_EN
  logic [WIDTH-1:0] w_glitch;
  logic [16:0]      w_gsum;
  logic [15:0]      r_glitch;

  always_comb begin
    w_gsum = {1'b0, r_glitch};
    for (int i = 0; i < WIDTH; i++) begin
      w_glitch[i] = (r_cnt[i] != '0) && (w_s[i] == r_f[i]);
      w_gsum      = w_gsum + 17'(w_glitch[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_glitch <= '0;
    end else if (w_gsum[16]) begin
      r_glitch <= 16'hFFFF;
    end else begin
      r_glitch <= w_gsum[15:0];
    end
  end

  assign glitch_cnt_o = r_glitch;
`else
  assign glitch_cnt_o = 16'h0000;
`endif

  assign upio_in_o  = r_f;
  assign rise_o     = r_rise;
  assign fall_o     = r_fall;
  assign evt_pend_o = r_pend;
  assign irq_o      = |(r_pend & irq_mask_i);

endmodule

// File: doc/upio_in_cond.md
Name: upio_in_cond

Overview:
- Input-conditioning stage directly upstream of the user plugin's 8-bit UPIO input (`upio_in_i`).
- Synchronises asynchronous pad inputs and debounces each bit with its own counter.
- Produces single-cycle rise/fall pulses and sticky, maskable event flags.
- Drives a level interrupt that is OR-ed into the plugin's interrupt path.

Parameters:
- WIDTH, 8, number of conditioned input bits.
- SYNC_STAGES, 2, synchroniser flip-flop depth (legal range ≥2).
- CNT_WIDTH, 8, width of each per-bit debounce counter and of `deb_len_i`.

Ports:
- `clk_i`  in  1  clock (single clock domain).
- `rst_i`  in  1  reset, asynchronous, active-high.
- `pad_i`  in  WIDTH  raw asynchronous pad inputs.
- `deb_len_i`  in  CNT_WIDTH  debounce threshold; 0 means 1-cycle filter.
- `rise_en_i`  in  WIDTH  per-bit enable: rising edge sets the pending flag.
- `fall_en_i`  in  WIDTH  per-bit enable: falling edge sets the pending flag.
- `irq_mask_i`  in  WIDTH  per-bit interrupt mask; 1 means enabled.
- `evt_clr_i`  in  WIDTH  per-bit pending-clear strobe, 1 cycle.
- `upio_in_o`  out  WIDTH  debounced level; feeds plugin `upio_in_i`.
- `rise_o`  out  WIDTH  1-cycle pulse on debounced 0→1.
- `fall_o`  out  WIDTH  1-cycle pulse on debounced 1→0.
- `evt_pend_o`  out  WIDTH  sticky pending event flags.
- `irq_o`  out  1  OR of (`evt_pend_o` & `irq_mask_i`).
- `glitch_cnt_o`  out  16  rejected-glitch count (optional feature, see below).

Behaviour:
- Reset:
  - Asynchronous on `rst_i` high.
  - All synchroniser stages, debounced levels f, counters, `rise_o`, `fall_o`, `evt_pend_o` and `glitch_cnt_o` clear to 0.
  - `irq_o` is therefore 0.
  - Reset asserted mid-count discards the count; no edge pulse is produced.
- Synchroniser: an SYNC_STAGES-deep flip-flop chain per bit; its output is s. No reset-release special case.
- Debounce, per bit i, evaluated at each rising edge of `clk_i`:
  - s==f: cnt<=0.
  - s!=f and cnt>=`deb_len_i`: f<=s, cnt<=0. Assert `rise_o`[i] if s=1, else `fall_o`[i], registered, high for exactly 1 cycle.
  - s!=f and cnt<`deb_len_i`: cnt<=cnt+1.
  - The comparison is >=, so lowering `deb_len_i` mid-count takes effect on the next edge.
  - cnt never exceeds `deb_len_i`, so no wrap occurs.
- Latency:
  - pad_i stable from sampling edge 0 → `upio_in_o` and the pulse update at edge SYNC_STAGES+`deb_len_i`.
  - Defaults with `deb_len_i`=3: edge 5.
- Glitch rejection: an s excursion lasting ≤`deb_len_i` cycles never changes f.
- Pending flags:
  - Set: pend[i]<=1 when (`rise_o`[i]&`rise_en_i`[i]) | (`fall_o`[i]&`fall_en_i`[i]).
  - The flag is set on the cycle after the pulse edge, i.e. it tracks the registered pulse.
  - Clear: pend[i]<=0 on `evt_clr_i`[i].
  - Simultaneous set and clear: set wins.
- Interrupt: `irq_o` is combinational from the pend registers and `irq_mask_i`; no added latency.
- Bit independence: all bits are fully independent; any combination may toggle in the same cycle.

Optional Feature:
- Macro: UPIO_COND_GLITCH_CNT_EN.
- Defined:
  - A 16-bit counter increments by 1 per edge for each bit where cnt!=0 and s==f, i.e. a rejected excursion.
  - Multiple bits in one cycle add their popcount.
  - The counter saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: `glitch_cnt_o` tied to 16'h0000; no counter logic.

Test Plan:
- Reset check: hold `rst_i`=1, toggle `pad_i`=8'hFF → all outputs 0. Release reset with pad stable 8'hA5, `deb_len_i`=3 → `upio_in_o`=8'hA5 at edge 5 after release. `rise_o`=8'hA5 for exactly 1 cycle.
- Glitch rejection: `deb_len_i`=4, `pad_i`[0] 0→1 for 3 cycles then back → `upio_in_o`[0] stays 0, no pulse. `glitch_cnt_o`=1 if enabled.
- Edge events: `rise_en_i`=8'h01, `fall_en_i`=8'h02, `irq_mask_i`=8'h03. Stable toggles on bits 0,1 (bit0 0→1, bit1 1→0) → `evt_pend_o`=8'h03 and `irq_o`=1. `evt_clr_i`=8'h01 → `evt_pend_o`=8'h02, `irq_o` stays 1.
- Set/clear collision: `evt_clr_i`[2] pulsed on the same edge as an enabled `rise_o`[2] → `evt_pend_o`[2]=1.
- Threshold change: `deb_len_i`=200, toggle bit 3, after 10 cycles set `deb_len_i`=5 → f updates on the next edge (cnt 10≥5).
- Async reset mid-operation: assert `rst_i` mid-debounce with cnt=2 → counters, `evt_pend_o` and `irq_o` go to 0 immediately without waiting for a clock; no pulse after release until a new qualified change.
